// File: rtl/sc_io_pkg.sv
// Shared constants for the single-cycle computer input conditioning stage.
// Optional press counter is enabled with the SC_IO_PRESS_CNT_EN macro.
package sc_io_pkg;

    localparam int IO_PORT_W     = 32;
    localparam int SW_W_DEF      = 10;
    localparam int KEY_W_DEF     = 4;
    localparam int DB_CYCLES_DEF = 50000;
    localparam int PRESS_CNT_W   = 16;

    // Reset levels: switches read as off, keys as released (active-low pins),
    // so leaving reset never looks like a press.
    localparam logic SW_RST_LVL  = 1'b0;
    localparam logic KEY_RST_LVL = 1'b1;

    // Number of set bits in a 16-bit vector (keys are at most 16 wide).
    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sc_io_debounce_bit.sv
// One input channel: 2-FF synchroniser followed by a counting debouncer.
// The stable level only moves after the synchronised input has disagreed
// with it for DB_CYCLES consecutive edges; any agreement restarts the window.
module sc_io_debounce_bit #(
    parameter int   DB_CYCLES = 4,
    parameter logic RST_LVL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Debounce window: count disagreement, commit on the last cycle of it.
    always_comb begin
        st_d  = st_q;
        cnt_d = '0;
        if (s2_q != st_q) begin
            if (cnt_q == CNT_MAX) begin
                st_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser, stable level and window counter; reset drops any pending change.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q  <= RST_LVL;
            s2_q  <= RST_LVL;
            st_q  <= RST_LVL;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    assign stable_o = st_q;

endmodule

// File: rtl/sc_io_input.sv
// Input conditioning for the data memory / IO block: debounced switches and
// keys, sticky key-press flags cleared by the CPU, and an optional 16-bit
// press counter built only when SC_IO_PRESS_CNT_EN is defined.
module sc_io_input
    import sc_io_pkg::*;
#(
    parameter int SW_W      = SW_W_DEF,
    parameter int KEY_W     = KEY_W_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [SW_W-1:0]      sw,
    input  logic [KEY_W-1:0]     key_n,
    input  logic [KEY_W-1:0]     ack,
    output logic [IO_PORT_W-1:0] in_port0,
    output logic [IO_PORT_W-1:0] in_port1,
    output logic [IO_PORT_W-1:0] in_port2,
    output logic [IO_PORT_W-1:0] in_port3
);

    logic [SW_W-1:0]  sw_st;
    logic [KEY_W-1:0] key_st;
    logic [KEY_W-1:0] key_pressed;
    logic [KEY_W-1:0] kp_dly_q;
    logic [KEY_W-1:0] press_ev;
    logic [KEY_W-1:0] flag_q, flag_d;

    for (genvar gi = 0; gi < SW_W; gi++) begin : g_sw
        sc_io_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .RST_LVL   (SW_RST_LVL)
        ) u_db (
            .clk_i    (clock),
            .rst_ni   (resetn),
            .raw_i    (sw[gi]),
            .stable_o (sw_st[gi])
        );
    end

    for (genvar gk = 0; gk < KEY_W; gk++) begin : g_key
        sc_io_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .RST_LVL   (KEY_RST_LVL)
        ) u_db (
            .clk_i    (clock),
            .rst_ni   (resetn),
            .raw_i    (key_n[gk]),
            .stable_o (key_st[gk])
        );
    end

    assign key_pressed = ~key_st;
    assign press_ev    = key_pressed & ~kp_dly_q;

    // Sticky flags: a press event sets, ack clears, set wins when both coincide.
    always_comb begin
        flag_d = (flag_q & ~ack) | press_ev;
    end

    // Delayed key level for edge detection, plus the flag register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            kp_dly_q <= '0;
            flag_q   <= '0;
        end else begin
            kp_dly_q <= key_pressed;
            flag_q   <= flag_d;
        end
    end

`ifdef SC_IO_PRESS_CNT_EN
    logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [15:0]            ev16;

    // Every key pressed in the same cycle adds one; wraps naturally at 16 bits.
    always_comb begin
        ev16              = '0;
        ev16[KEY_W-1:0]   = press_ev;
        press_cnt_d       = press_cnt_q + PRESS_CNT_W'(popcnt16(ev16));
    end

    // Press counter, cleared only by reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            press_cnt_q <= '0;
        end else begin
            press_cnt_q <= press_cnt_d;
        end
    end

    assign in_port3 = IO_PORT_W'(press_cnt_q);
`else
    assign in_port3 = '0;
`endif

    assign in_port0 = IO_PORT_W'(sw_st);
    assign in_port1 = IO_PORT_W'(key_pressed);
    assign in_port2 = IO_PORT_W'(flag_q);

endmodule
